adj_accum_scheduler: RTL and testbench

Sequences the read-modify-write accumulation of FM_WM rows into the ADJ memory for every COO edge once transformation finishes. It replaces the one-op-per-two-cycle combination sequencing with a pipelined schedule that issues one accumulate op per cycle. It expands each edge into forward and reverse ops in undirected mode, and resolves read-after-write hazards on ADJ rows by steering the datapath to a forwarded sum. It sits between the transformation stage, the COO memory, the FM_WM memory and the ADJ accumulate datapath.

---
 rtl/gcn_pkg.sv | 16 +
 rtl/adj_rmw_stage.sv | 33 +++
 rtl/adj_accum_scheduler.sv | 116 +++++++++++
 tb/tb_adj_accum_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// Shared GCN pipeline types: accumulate-scheduler FSM states and op phase.
package gcn_pkg;

    typedef enum logic {
        OP_FWD,
        OP_REV
    } op_phase_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } adj_sched_state_t;

endpackage

// File: rtl/adj_rmw_stage.sv
// One-deep write stage for the ADJ read-modify-write pipe.
// Latency 1 cycle R->W; no backpressure, the hazard flag steers forwarding instead of stalling.
// Backpressure: none, it accepts one op every cycle.
module adj_rmw_stage #(
    parameter int NODE_ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   r_valid,
    input  logic [NODE_ADDR_W-1:0] r_target,
    output logic                   w_valid,
    output logic [NODE_ADDR_W-1:0] w_target,
    output logic                   fwd_sel
);

    logic hazard;

    // The row read this cycle is stale if the op ahead of it writes the same row now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_valid  <= 1'b0;
            w_target <= '0;
            hazard   <= 1'b0;
        end else begin
            w_valid  <= r_valid;
            w_target <= r_target;
            hazard   <= r_valid && w_valid && (r_target == w_target);
        end
    end

    assign fwd_sel = w_valid && hazard;

endmodule

// File: rtl/adj_accum_scheduler.sv
// Issues one ADJ accumulate op per cycle for every COO edge, forward plus reverse when undirected.
// Latency: first read 1 cycle after start, each write 1 cycle after its read, done 2 cycles after last read.
// Backpressure: none; start is ignored while busy, RAW hazards are forwarded rather than stalled.
module adj_accum_scheduler
    import gcn_pkg::*;
#(
    parameter int NUM_NODES   = 6,
    parameter int NODE_ADDR_W = $clog2(NUM_NODES),
    parameter int NUM_EDGES   = 6,
    parameter int EDGE_ADDR_W = $clog2(NUM_EDGES),
    parameter bit UNDIRECTED  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NODE_ADDR_W-1:0] coo_src,
    input  logic [NODE_ADDR_W-1:0] coo_dst,
    output logic [EDGE_ADDR_W-1:0] coo_addr,
    output logic [NODE_ADDR_W-1:0] fm_rd_addr,
    output logic                   adj_rd_en,
    output logic [NODE_ADDR_W-1:0] adj_rd_addr,
    output logic                   adj_wr_en,
    output logic [NODE_ADDR_W-1:0] adj_wr_addr,
    output logic                   fwd_sel,
    output logic                   busy,
    output logic                   done
);

    localparam logic [EDGE_ADDR_W-1:0] LAST_EDGE = EDGE_ADDR_W'(NUM_EDGES - 1);

    adj_sched_state_t       state, state_nxt;
    op_phase_t              phase, phase_nxt;
    logic [EDGE_ADDR_W-1:0] edge_ptr, edge_ptr_nxt;
    logic                   issuing;
    logic                   last_op_of_edge;
    logic [NODE_ADDR_W-1:0] r_target;
    logic [NODE_ADDR_W-1:0] r_fm;
    logic                   w_valid;
    logic [NODE_ADDR_W-1:0] w_target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= OP_FWD;
            edge_ptr <= '0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            edge_ptr <= edge_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        phase_nxt       = phase;
        edge_ptr_nxt    = edge_ptr;
        issuing         = 1'b0;
        r_target        = '0;
        r_fm            = '0;
        // A self-loop would accumulate the same row twice, so it only gets the forward op.
        last_op_of_edge = (phase == OP_REV) || !UNDIRECTED || (coo_src == coo_dst);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt    = ISSUE;
                    phase_nxt    = OP_FWD;
                    edge_ptr_nxt = '0;
                end
            end
            ISSUE: begin
                issuing = 1'b1;
                if (phase == OP_FWD) begin
                    r_target = coo_dst;
                    r_fm     = coo_src;
                end else begin
                    r_target = coo_src;
                    r_fm     = coo_dst;
                end
                if (!last_op_of_edge) begin
                    phase_nxt = OP_REV;
                end else begin
                    phase_nxt = OP_FWD;
                    if (edge_ptr == LAST_EDGE) begin
                        state_nxt = DRAIN;
                    end else begin
                        edge_ptr_nxt = edge_ptr + EDGE_ADDR_W'(1);
                    end
                end
            end
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    adj_rmw_stage #(
        .NODE_ADDR_W(NODE_ADDR_W)
    ) u_rmw (
        .clk     (clk),
        .reset   (reset),
        .r_valid (issuing),
        .r_target(r_target),
        .w_valid (w_valid),
        .w_target(w_target),
        .fwd_sel (fwd_sel)
    );

    assign coo_addr    = edge_ptr;
    assign adj_rd_en   = issuing;
    assign adj_rd_addr = r_target;
    assign fm_rd_addr  = r_fm;
    assign adj_wr_en   = w_valid;
    assign adj_wr_addr = w_valid ? w_target : '0;
    assign busy        = (state == ISSUE) || (state == DRAIN);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_adj_accum_scheduler.sv
// Bench for adj_accum_scheduler: an undirected and a directed instance driven from edge tables,
// random edge lists and hand sequences, compared cycle by cycle against an op-list model.
module tb_adj_accum_scheduler;

    localparam int NE = 6;
    localparam int AW = 3;

    typedef struct packed {
        logic [2:0] coo_addr;
        logic [2:0] fm;
        logic       rd_en;
        logic [2:0] rd;
        logic       wr_en;
        logic [2:0] wr;
        logic       fwd;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        bit              und;
        logic [3*NE-1:0] s;
        logic [3*NE-1:0] d;
        int              exp_n;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic start_u, start_d;
    logic [AW-1:0] src_u [NE];
    logic [AW-1:0] dst_u [NE];
    logic [AW-1:0] src_d [NE];
    logic [AW-1:0] dst_d [NE];

    logic [2:0] coo_src_u, coo_dst_u, coo_addr_u, fm_u, rd_addr_u, wr_addr_u;
    logic       rd_en_u, wr_en_u, fwd_u, busy_u, done_u;
    logic [2:0] coo_src_d, coo_dst_d, coo_addr_d, fm_d, rd_addr_d, wr_addr_d;
    logic       rd_en_d, wr_en_d, fwd_d, busy_d, done_d;
    obs_t obs_u, obs_d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign coo_src_u = src_u[coo_addr_u];
    assign coo_dst_u = dst_u[coo_addr_u];
    assign coo_src_d = src_d[coo_addr_d];
    assign coo_dst_d = dst_d[coo_addr_d];
    assign obs_u = {coo_addr_u, fm_u, rd_en_u, rd_addr_u, wr_en_u, wr_addr_u, fwd_u, busy_u, done_u};
    assign obs_d = {coo_addr_d, fm_d, rd_en_d, rd_addr_d, wr_en_d, wr_addr_d, fwd_d, busy_d, done_d};

    adj_accum_scheduler #(.NUM_NODES(6), .NUM_EDGES(6), .UNDIRECTED(1'b1)) dut_u (
        .clk(clk), .reset(reset), .start(start_u),
        .coo_src(coo_src_u), .coo_dst(coo_dst_u), .coo_addr(coo_addr_u),
        .fm_rd_addr(fm_u), .adj_rd_en(rd_en_u), .adj_rd_addr(rd_addr_u),
        .adj_wr_en(wr_en_u), .adj_wr_addr(wr_addr_u), .fwd_sel(fwd_u),
        .busy(busy_u), .done(done_u)
    );

    adj_accum_scheduler #(.NUM_NODES(6), .NUM_EDGES(6), .UNDIRECTED(1'b0)) dut_d (
        .clk(clk), .reset(reset), .start(start_d),
        .coo_src(coo_src_d), .coo_dst(coo_dst_d), .coo_addr(coo_addr_d),
        .fm_rd_addr(fm_d), .adj_rd_en(rd_en_d), .adj_rd_addr(rd_addr_d),
        .adj_wr_en(wr_en_d), .adj_wr_addr(wr_addr_d), .fwd_sel(fwd_d),
        .busy(busy_d), .done(done_d)
    );

    vec_t cur;
    vec_t vecs [4];
    int   op_tgt [$];
    int   op_fm  [$];
    int   op_edge[$];

    function automatic logic [3*NE-1:0] pk(input int e0, e1, e2, e3, e4, e5);
        return {3'(e5), 3'(e4), 3'(e3), 3'(e2), 3'(e1), 3'(e0)};
    endfunction

    // Model: expand the edge list into an ordered list of (target row, fm row, edge) ops.
    task automatic build_model();
        int s, d;
        op_tgt.delete(); op_fm.delete(); op_edge.delete();
        for (int e = 0; e < NE; e++) begin
            s = int'(cur.s[e*3 +: 3]);
            d = int'(cur.d[e*3 +: 3]);
            op_tgt.push_back(d); op_fm.push_back(s); op_edge.push_back(e);
            if (cur.und && s != d) begin
                op_tgt.push_back(s); op_fm.push_back(d); op_edge.push_back(e);
            end
        end
    endtask

    function automatic obs_t expect_at(input int c);
        obs_t e;
        int   n;
        e = '0;
        n = op_tgt.size();
        if (c >= 1 && c <= n) begin
            e.rd_en    = 1'b1;
            e.rd       = 3'(op_tgt[c-1]);
            e.fm       = 3'(op_fm[c-1]);
            e.coo_addr = 3'(op_edge[c-1]);
        end else if (c > n) begin
            e.coo_addr = 3'(NE - 1);
        end
        if (c >= 2 && c <= n + 1) begin
            e.wr_en = 1'b1;
            e.wr    = 3'(op_tgt[c-2]);
            e.fwd   = (c >= 3) && (op_tgt[c-2] == op_tgt[c-3]);
        end
        e.busy = (c >= 1) && (c <= n + 1);
        e.done = (c >= n + 2);
        return e;
    endfunction

    // Addresses are only meaningful while their strobe is high.
    task automatic check_obs(input string name, input int c, input obs_t got, input obs_t exp);
        obs_t mm;
        logic [16:0] m;
        mm = '1;
        if (!exp.rd_en) begin
            mm.rd = '0;
            mm.fm = '0;
        end
        if (!exp.wr_en) mm.wr = '0;
        m = mm;
        total++;
        if ((17'(got) & m) !== (17'(exp) & m)) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h required %h (mask %h)", name, c, got, exp, m);
        end
    endtask

    task automatic run_sched(input bit sel_d, input int pulse, input string name);
        int   n;
        int   writes;
        obs_t got;
        build_model();
        n = op_tgt.size();
        for (int i = 0; i < NE; i++) begin
            if (sel_d) begin
                src_d[i] = cur.s[i*3 +: 3];
                dst_d[i] = cur.d[i*3 +: 3];
            end else begin
                src_u[i] = cur.s[i*3 +: 3];
                dst_u[i] = cur.d[i*3 +: 3];
            end
        end
        @(negedge clk);
        if (sel_d) start_d = 1'b1; else start_u = 1'b1;
        writes = 0;
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            start_u = 1'b0;
            start_d = 1'b0;
            got = sel_d ? obs_d : obs_u;
            check_obs(name, c, got, expect_at(c));
            if (got.wr_en) writes++;
            if (c == pulse) begin
                if (sel_d) start_d = 1'b1; else start_u = 1'b1;
            end
        end
        total++;
        if (writes != cur.exp_n) begin
            bad++;
            $display("FAIL %s write_count: got %0d required %0d", name, writes, cur.exp_n);
        end
    endtask

    initial begin
        int loops;
        obs_t got;

        vecs[0] = '{1'b1, pk(0, 1, 3, 5, 2, 4), pk(5, 2, 4, 1, 3, 0), 12};
        vecs[1] = '{1'b0, pk(2, 4, 0, 1, 5, 3), pk(3, 3, 1, 2, 0, 4), 6};
        vecs[2] = '{1'b1, pk(0, 1, 3, 5, 2, 4), pk(5, 1, 4, 1, 3, 0), 11};
        vecs[3] = '{1'b1, pk(0, 3, 3, 2, 4, 5), pk(1, 0, 3, 4, 2, 5), 10};

        reset   = 1'b1;
        start_u = 1'b0;
        start_d = 1'b0;
        for (int i = 0; i < NE; i++) begin
            src_u[i] = '0; dst_u[i] = '0; src_d[i] = '0; dst_d[i] = '0;
        end
        #1;
        check_obs("reset_u", 0, obs_u, '0);
        check_obs("reset_d", 0, obs_d, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int vi = 0; vi < 4; vi++) begin
            cur = vecs[vi];
            run_sched(!cur.und, -1, $sformatf("table%0d", vi));
        end

        // start while busy must not disturb the schedule
        cur = vecs[0];
        run_sched(1'b0, 4, "start_busy");

        for (int r = 0; r < 8; r++) begin
            cur.und = (r % 2) == 0;
            loops   = 0;
            for (int i = 0; i < NE; i++) begin
                cur.s[i*3 +: 3] = 3'($urandom_range(0, 5));
                cur.d[i*3 +: 3] = (r >= 4 && i < 2) ? cur.s[i*3 +: 3] : 3'($urandom_range(0, 5));
                if (cur.s[i*3 +: 3] == cur.d[i*3 +: 3]) loops++;
            end
            cur.exp_n = NE * (cur.und ? 2 : 1) - (cur.und ? loops : 0);
            run_sched(!cur.und, -1, $sformatf("random%0d", r));
        end

        // reset in the middle of ISSUE
        cur = vecs[0];
        build_model();
        for (int i = 0; i < NE; i++) begin
            src_u[i] = cur.s[i*3 +: 3];
            dst_u[i] = cur.d[i*3 +: 3];
        end
        @(negedge clk);
        start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        repeat (4) @(negedge clk);
        check_obs("pre_reset", 5, obs_u, expect_at(5));
        reset = 1'b1;
        #1;
        check_obs("async_reset", 5, obs_u, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) reset = 1'b0;
            got = obs_u;
            total++;
            if (got.wr_en !== 1'b0 || got.busy !== 1'b0 || got.done !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_quiet step %0d: got wr_en=%b busy=%b done=%b required 0 0 0",
                         k, got.wr_en, got.busy, got.done);
            end
        end
        run_sched(1'b0, -1, "rerun_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
